// File: rtl/mem_arb_ctrl.sv
// Two-requester round-robin sequencer for a single-port byte memory with
// load->write / load->read protocol and a controller-owned tri-state data bus.
module mem_arb_ctrl #(
  parameter int SIZE = 20
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            req0_valid,
  input  logic            req0_write,
  input  logic [SIZE-1:0] req0_addr,
  input  logic [7:0]      req0_wdata,
  output logic            req0_ready,
  output logic            req0_done,
  input  logic            req1_valid,
  input  logic            req1_write,
  input  logic [SIZE-1:0] req1_addr,
  input  logic [7:0]      req1_wdata,
  output logic            req1_ready,
  output logic            req1_done,
  output logic [7:0]      rdata,
  output logic [SIZE-1:0] mem_addr,
  output logic            mem_load,
  output logic            mem_write,
  output logic            mem_oe,
  inout  wire  [7:0]      DATA
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RD   = 2'd3;

  logic [1:0]            r_state;
  logic                  r_last;
  logic                  r_owner;
  logic                  r_we;
  logic [SIZE-1:0]       r_addr;
  logic [7:0]            r_wdata;
  logic [7:0]            r_rdata;
  logic [1:0]            r_done;

  logic [1:0]            w_valid;
  logic [1:0]            w_write;
  logic [1:0][SIZE-1:0]  w_addr;
  logic [1:0][7:0]       w_wdata;
  logic                  w_sel;
  logic                  w_grant;

  assign w_valid = {req1_valid, req0_valid};
  assign w_write = {req1_write, req0_write};
  assign w_addr  = {req1_addr, req0_addr};
  assign w_wdata = {req1_wdata, req0_wdata};

  // On a tie the requester that did not win last time gets the slot.
  assign w_sel   = (w_valid == 2'b11) ? ~r_last : w_valid[1];
  assign w_grant = RST_N && (r_state == S_IDLE) && (|w_valid);

  assign req0_ready = w_grant && !w_sel;
  assign req1_ready = w_grant &&  w_sel;
  assign req0_done  = r_done[0];
  assign req1_done  = r_done[1];
  assign rdata      = r_rdata;
  assign mem_addr   = r_addr;

  // Strobes are gated by reset so an aborted op has no memory side effect.
  assign mem_load  = RST_N && (r_state == S_LOAD);
  assign mem_write = RST_N && (r_state == S_WR);
  assign mem_oe    = RST_N && (r_state == S_RD);
  assign DATA      = mem_write ? r_wdata : 8'bz;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_done  <= '0;
    end else begin
      r_done <= ((r_state == S_WR) || (r_state == S_RD)) ? (2'b01 << r_owner) : 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_addr  <= w_addr[w_sel];
            r_wdata <= w_wdata[w_sel];
            r_we    <= w_write[w_sel];
            r_owner <= w_sel;
            r_last  <= w_sel;
            r_state <= S_LOAD;
          end
        end
        S_LOAD:  r_state <= r_we ? S_WR : S_RD;
        S_WR:    r_state <= S_IDLE;
        default: begin
          r_rdata <= DATA;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl with a behavioural byte memory on the DATA bus
// and a reference byte model for read-data expectations.
module tb_mem_arb_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [19:0] req0_addr, req1_addr;
  logic [7:0]  req0_wdata, req1_wdata;
  logic        req0_ready, req0_done, req1_ready, req1_done;
  logic [7:0]  rdata;
  logic [19:0] mem_addr;
  logic        mem_load, mem_write, mem_oe;
  wire  [7:0]  DATA;

  int n_chk  = 0;
  int n_pass = 0;
  int viol   = 0;

  always #5 CLK = ~CLK;

  mem_arb_ctrl #(.SIZE(20)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .rdata(rdata), .mem_addr(mem_addr), .mem_load(mem_load),
    .mem_write(mem_write), .mem_oe(mem_oe), .DATA(DATA)
  );

  // Preloaded memory image: distinct values at 0 (0x3C) and 0xFFFFF (0xCC).
  function automatic logic [7:0] init_b(input logic [19:0] a);
    return a[7:0] ^ 8'h3C ^ {4'h0, a[19:16]};
  endfunction

  logic [7:0]  mem [0:(1<<20)-1];
  logic [19:0] m_areg = '0;
  assign DATA = mem_oe ? mem[m_areg] : 8'bz;
  always @(posedge CLK) begin
    if (mem_load)  m_areg <= mem_addr;
    if (mem_write) mem[m_areg] <= DATA;
  end

  always @(negedge CLK)
    if ((mem_write && mem_oe) || (mem_load && mem_write) || (mem_load && mem_oe)) viol++;

  logic [7:0] ref_m [logic [19:0]];
  function automatic logic [7:0] model_rd(input logic [19:0] a);
    return ref_m.exists(a) ? ref_m[a] : init_b(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  // One transaction with full latency checks; returns cycles waited for ready.
  task automatic do_op(input int r, input bit wr, input logic [19:0] a,
                       input logic [7:0] d, output int waits);
    logic [7:0] exp_rd;
    logic rdy;
    exp_rd = model_rd(a);
    if (r == 0) begin
      req0_valid = 1; req0_write = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1; req1_write = wr; req1_addr = a; req1_wdata = d;
    end
    #1;
    waits = 0;
    rdy = (r == 0) ? req0_ready : req1_ready;
    while (!rdy && waits < 20) begin
      cyc(); waits++;
      rdy = (r == 0) ? req0_ready : req1_ready;
    end
    chk("accept", {31'd0, rdy}, 32'd1);
    cyc();
    req0_valid = 0; req1_valid = 0;
    chk("load", {11'd0, mem_load, mem_addr}, {11'd1, a});
    cyc();
    if (wr) chk("wr_phase", {22'd0, mem_write, mem_oe, DATA}, {22'd0, 2'b10, d});
    else    chk("rd_phase", {30'd0, mem_write, mem_oe}, 32'd1);
    cyc();
    chk("done", {30'd0, req1_done, req0_done}, (r == 0) ? 32'd1 : 32'd2);
    if (wr) ref_m[a] = d;
    else    chk("rdata", {24'd0, rdata}, {24'd0, exp_rd});
  endtask

  initial begin
    int w;
    for (int i = 0; i < (1 << 20); i++) mem[i] = init_b(20'(i));
    RST_N = 0;
    req0_valid = 1; req0_write = 1; req0_addr = 20'h1; req0_wdata = 8'h10;
    req1_valid = 1; req1_write = 1; req1_addr = 20'h2; req1_wdata = 8'h20;

    // Reset with both requesters valid: everything quiet.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_outs", {16'd0, req0_ready, req1_ready, req0_done, req1_done,
                       mem_load, mem_write, mem_oe, 1'b0, rdata},
          32'd0);
    end
    chk("rst_addr", {12'd0, mem_addr}, 32'd0);

    // Release with both valid: req0 first, grants alternate every 3 cycles.
    RST_N = 1; #1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("rr_k%0d", k), {30'd0, req0_ready, req1_ready},
          {30'd0, (k % 6 == 0), (k % 6 == 3)});
      cyc();
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_last_done", {30'd0, req1_done, req0_done}, 32'd2);
    ref_m[20'h1] = 8'h10; ref_m[20'h2] = 8'h20;
    do_op(0, 0, 20'h1, 8'h0, w); chk("rb_a1", {24'd0, rdata}, 32'h10);
    do_op(1, 0, 20'h2, 8'h0, w); chk("rb_a2", {24'd0, rdata}, 32'h20);

    // Single write then readback.
    do_op(0, 1, 20'h00005, 8'hA5, w);
    do_op(0, 0, 20'h00005, 8'h00, w);
    chk("rd_a5", {24'd0, rdata}, 32'hA5);

    // req1 back-to-back reads at the address extremes.
    do_op(1, 0, 20'h00000, 8'h00, w);
    chk("rd_min", {24'd0, rdata}, 32'h3C);
    do_op(1, 0, 20'hFFFFF, 8'h00, w);
    chk("b2b_wait", w, 0);
    chk("rd_max", {24'd0, rdata}, 32'hCC);

    // Reset during WR aborts the write with no done.
    req0_valid = 1; req0_write = 1; req0_addr = 20'h33; req0_wdata = 8'h77; #1;
    chk("abort_acc", {31'd0, req0_ready}, 32'd1);
    cyc(); req0_valid = 0;
    cyc();
    chk("abort_inwr", {31'd0, mem_write}, 32'd1);
    RST_N = 0; #1;
    chk("abort_wr_off", {30'd0, mem_write, mem_oe}, 32'd0);
    cyc(); RST_N = 1; #1;
    chk("abort_nodone", {30'd0, req1_done, req0_done}, 32'd0);
    cyc();
    chk("abort_nodone2", {30'd0, req1_done, req0_done}, 32'd0);
    do_op(0, 0, 20'h33, 8'h00, w);
    chk("abort_kept", {24'd0, rdata}, 32'h0F);

    // Random traffic against the reference model.
    for (int n = 0; n < 1000; n++) begin
      logic [19:0] a;
      a = ($urandom_range(0, 7) == 0) ? 20'hFFFFF - 20'($urandom_range(0, 3))
                                      : 20'($urandom_range(0, 15));
      do_op($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, 8'($urandom), w);
    end

    chk("bus_conflicts", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
